// File: rtl/if_fetch_stage_if.sv
// Bus bundle between the fetch stage and its neighbours: PC adder, instruction memory and decode.
// master = fetch stage side, slave = environment side.
interface if_fetch_stage_if;
    logic [31:0] next_pc;
    logic        flush;
    logic [31:0] pc_out;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    modport master (
        input  next_pc, flush, imem_ack, imem_rdata, id_ready,
        output pc_out, imem_req, imem_addr, id_valid, id_instr, id_pc
    );

    modport slave (
        output next_pc, flush, imem_ack, imem_rdata, id_ready,
        input  pc_out, imem_req, imem_addr, id_valid, id_instr, id_pc
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack and hands words to decode over valid/ready.
// Optional IF_STALL_CNT_EN adds a saturating stall_count output.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               reset,
    if_fetch_stage_if.master   bus
`ifdef IF_STALL_CNT_EN
    ,
    output logic [31:0]        stall_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] id_pc_q;

    assign bus.pc_out    = pc_q;
    assign bus.imem_addr = pc_q;
    assign bus.imem_req  = (state_q == S_FETCH);
    assign bus.id_valid  = (state_q == S_HOLD);
    assign bus.id_instr  = instr_q;
    assign bus.id_pc     = id_pc_q;

    // Flush wins over a same-cycle ack, so a redirected fetch never reaches decode.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            id_pc_q <= 32'h0;
        end else if (bus.flush) begin
            pc_q    <= bus.next_pc;
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_FETCH;
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        instr_q <= bus.imem_rdata;
                        id_pc_q <= pc_q;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.id_ready) begin
                        pc_q    <= bus.next_pc;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] stall_d;
    logic        stall_cyc;

    always_comb begin
        stall_cyc = ((state_q == S_FETCH) && !bus.imem_ack) ||
                    ((state_q == S_HOLD)  && !bus.id_ready);
        stall_d   = stall_q;
        if (stall_cyc && (stall_q != 32'hFFFF_FFFF))
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) stall_q <= 32'h0;
        else       stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: reset, streaming, table-driven stall/jump transactions,
// flush and mid-hold reset corner cases, with a scoreboard of expected decode hand-offs.
module tb_if_fetch_stage;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        ack;
    logic        ready;
    logic        jump_en;
    logic [31:0] jump_pc;
    logic [31:0] rdata;

    if_fetch_stage_if bus ();

    assign bus.flush      = flush;
    assign bus.imem_ack   = ack;
    assign bus.id_ready   = ready;
    assign bus.imem_rdata = rdata;
    // Stand-in PC adder: sequential unless a jump target is forced.
    assign bus.next_pc    = jump_en ? jump_pc : bus.pc_out + 32'd1;

`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_w;
    if_fetch_stage #(.RESET_PC(32'h0)) dut (.clock(clock), .reset(reset), .bus(bus), .stall_count(stall_w));
`else
    if_fetch_stage #(.RESET_PC(32'h0)) dut (.clock(clock), .reset(reset), .bus(bus));
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] exp_pc;
        logic [31:0] rd;
        int          ack_wait;
        int          rdy_wait;
        logic        jmp;
        logic [31:0] jmp_pc;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pop_cmp(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            check({nm, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({nm, "_valid"}, {31'd0, bus.id_valid}, 32'd1);
            check({nm, "_id_pc"}, bus.id_pc, e.pc);
            check({nm, "_id_instr"}, bus.id_instr, e.instr);
        end
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_pc_out"},   bus.pc_out, 32'h0);
        check({nm, "_addr"},     bus.imem_addr, 32'h0);
        check({nm, "_req"},      {31'd0, bus.imem_req}, 32'd0);
        check({nm, "_valid"},    {31'd0, bus.id_valid}, 32'd0);
        check({nm, "_id_instr"}, bus.id_instr, 32'h0);
        check({nm, "_id_pc"},    bus.id_pc, 32'h0);
`ifdef IF_STALL_CNT_EN
        check({nm, "_stall"},    stall_w, 32'h0);
`endif
    endtask

    task automatic run_vec(input vec_t v);
`ifdef IF_STALL_CNT_EN
        logic [31:0] s0;
        s0 = stall_w;
`endif
        check("vec_req", {31'd0, bus.imem_req}, 32'd1);
        check("vec_addr", bus.imem_addr, v.exp_pc);
        ack = 1'b0;
        for (int i = 0; i < v.ack_wait; i++) begin
            step();
            check("vec_addr_held", bus.imem_addr, v.exp_pc);
            check("vec_req_held", {31'd0, bus.imem_req}, 32'd1);
        end
        rdata = v.rd;
        ack   = 1'b1;
        sb.push_back('{pc: v.exp_pc, instr: v.rd});
        step();
        ack   = 1'b0;
        rdata = 32'h0;
        ready = 1'b0;
        for (int i = 0; i < v.rdy_wait; i++) begin
            step();
            check("vec_hold_valid", {31'd0, bus.id_valid}, 32'd1);
            check("vec_hold_pc", bus.pc_out, v.exp_pc);
            check("vec_hold_id_pc", bus.id_pc, v.exp_pc);
            check("vec_hold_instr", bus.id_instr, v.rd);
        end
        jump_en = v.jmp;
        jump_pc = v.jmp_pc;
        ready   = 1'b1;
        pop_cmp("vec");
        step();
        ready   = 1'b0;
        jump_en = 1'b0;
        check("vec_next_pc", bus.pc_out, v.jmp ? v.jmp_pc : v.exp_pc + 32'd1);
        check("vec_refetch", {31'd0, bus.imem_req}, 32'd1);
`ifdef IF_STALL_CNT_EN
        check("vec_stall_delta", stall_w - s0, v.ack_wait + v.rdy_wait);
`endif
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{exp_pc: 32'h0000_0004, rd: 32'h1111_0004, ack_wait: 0, rdy_wait: 0, jmp: 1'b0, jmp_pc: 32'h0};
        vecs[1] = '{exp_pc: 32'h0000_0005, rd: 32'hA5A5_0005, ack_wait: 3, rdy_wait: 0, jmp: 1'b0, jmp_pc: 32'h0};
        vecs[2] = '{exp_pc: 32'h0000_0006, rd: 32'h2000_0001, ack_wait: 0, rdy_wait: 4, jmp: 1'b1, jmp_pc: 32'hFFFF_FFFF};
        vecs[3] = '{exp_pc: 32'hFFFF_FFFF, rd: 32'h0BAD_F00D, ack_wait: 1, rdy_wait: 1, jmp: 1'b0, jmp_pc: 32'h0};
        vecs[4] = '{exp_pc: 32'h0000_0000, rd: 32'h1234_5678, ack_wait: 0, rdy_wait: 2, jmp: 1'b1, jmp_pc: 32'h0000_0100};
        vecs[5] = '{exp_pc: 32'h0000_0100, rd: 32'h5555_0101, ack_wait: 2, rdy_wait: 0, jmp: 1'b0, jmp_pc: 32'h0};

        reset = 1'b1; flush = 1'b0; ack = 1'b0; ready = 1'b0;
        jump_en = 1'b0; jump_pc = 32'h0; rdata = 32'h0;
        step();
        step();
        check_reset_vals("reset");
        reset = 1'b0;
        check("idle_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        check("first_req", {31'd0, bus.imem_req}, 32'd1);
        check("first_addr", bus.imem_addr, 32'h0);

        // Streaming with ack and ready tied high: one hand-off every other cycle.
        ack = 1'b1; ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c % 2 == 0) begin
                check("stream_req", {31'd0, bus.imem_req}, 32'd1);
                check("stream_novalid", {31'd0, bus.id_valid}, 32'd0);
                rdata = 32'hC0DE_0000 + (c / 2);
                sb.push_back('{pc: c / 2, instr: 32'hC0DE_0000 + (c / 2)});
            end else begin
                pop_cmp("stream");
            end
            step();
        end
        ack = 1'b0; ready = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Flush while holding redirects to 0x40 and drops id_valid.
        rdata = 32'h7777_0101; ack = 1'b1;
        step();
        ack = 1'b0;
        check("hold_valid", {31'd0, bus.id_valid}, 32'd1);
        flush = 1'b1; jump_en = 1'b1; jump_pc = 32'h40;
        step();
        flush = 1'b0; jump_en = 1'b0;
        check("flush_hold_valid", {31'd0, bus.id_valid}, 32'd0);
        check("flush_hold_req", {31'd0, bus.imem_req}, 32'd1);
        check("flush_hold_addr", bus.imem_addr, 32'h40);

        // Flush with a same-cycle ack: the returned word is discarded.
        rdata = 32'hDEAD_BEEF; ack = 1'b1; flush = 1'b1; jump_en = 1'b1; jump_pc = 32'h80;
        step();
        flush = 1'b0; jump_en = 1'b0; ack = 1'b0;
        check("flush_ack_valid", {31'd0, bus.id_valid}, 32'd0);
        check("flush_ack_instr", bus.id_instr, 32'h7777_0101);
        check("flush_ack_id_pc", bus.id_pc, 32'h101);
        check("flush_ack_addr", bus.imem_addr, 32'h80);
        check("flush_ack_req", {31'd0, bus.imem_req}, 32'd1);
        rdata = 32'h8080_0080; ack = 1'b1;
        sb.push_back('{pc: 32'h80, instr: 32'h8080_0080});
        step();
        ack = 1'b0;
        pop_cmp("refetch");

        // Reset while holding the instruction at 0x10.
        ready = 1'b1; jump_en = 1'b1; jump_pc = 32'h10;
        step();
        ready = 1'b0; jump_en = 1'b0;
        rdata = 32'h1010_1010; ack = 1'b1;
        step();
        ack = 1'b0;
        check("pre_reset_id_pc", bus.id_pc, 32'h10);
        reset = 1'b1;
        step();
        check_reset_vals("mid_reset");
        reset = 1'b0;
        check("restart_idle", {31'd0, bus.imem_req}, 32'd0);
        step();
        check("restart_req", {31'd0, bus.imem_req}, 32'd1);
        check("restart_addr", bus.imem_addr, 32'h0);

        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage that owns the program-counter register. It drives the current PC into the PC adder, loads the adder's next-address result, and fetches words from instruction memory over a req/ack handshake. It presents each instruction to decode over a valid/ready handshake. Addresses are word addresses: sequential PC is `pc + 1`.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `next_pc`  in  32: next address from the PC adder, computed from `pc_out`.
- `flush`  in  1: discard the held or in-flight instruction and redirect to `next_pc`.
- `pc_out`  out  32: current PC register; feeds the PC adder.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: fetch address; always equals `pc_out`.
- `imem_ack`  in  1: `imem_rdata` is valid for the current `imem_addr` this cycle.
- `imem_rdata`  in  32: instruction word.
- `id_valid`  out  1: `id_instr` and `id_pc` are valid.
- `id_ready`  in  1: decode accepts this cycle.
- `id_instr`  out  32: fetched instruction.
- `id_pc`  out  32: address of `id_instr`.
- `stall_count`  out  32: present only with `IF_STALL_CNT_EN`.

## Operation
- FSM states:
  - `S_IDLE`: entered from reset; exits to `S_FETCH` unconditionally.
  - `S_FETCH`: `imem_req=1`; waits for `imem_ack`.
  - `S_HOLD`: `id_valid=1`; waits for `id_ready`.
- Decoded outputs: `imem_req = (state==S_FETCH)`, `id_valid = (state==S_HOLD)`, `imem_addr = pc_out`.
- In `S_FETCH`, when `imem_ack=1` at the edge:
  - `id_instr <= imem_rdata`, `id_pc <= pc_out`.
  - Go to `S_HOLD`.
- In `S_FETCH`, when `imem_ack=0`: hold state; `pc_out` and `imem_addr` stay stable.
- In `S_HOLD`, when `id_ready=1` at the edge:
  - `pc_out <= next_pc`.
  - Go to `S_FETCH`.
- In `S_HOLD`, when `id_ready=0`: `id_instr`, `id_pc` and `pc_out` hold.
- `flush=1` at any edge, any state:
  - `pc_out <= next_pc`; next state is `S_FETCH`.
  - A same-cycle `imem_ack` is discarded: `id_instr`/`id_pc` unchanged and `id_valid` stays 0.
- Priority: `reset` > `flush` > normal transitions.
- `next_pc` is loaded verbatim; the block does no arithmetic on it. Wrap-around (`0xFFFFFFFF` to `0`) is the PC adder's concern.
- Memory contract:
  - The request stays high and the address stays stable until ack.
  - An address change with no ack, which happens only via flush, abandons the old request.

## Timing
- Reset values: `pc_out=RESET_PC`, `imem_addr=RESET_PC`, `imem_req=0`, `id_valid=0`, `id_instr=0`, `id_pc=0`, `stall_count=0`.
- `S_IDLE` lasts exactly one cycle. `imem_req` rises in the second cycle after the first edge with `reset=0`.
- `pc_out`, `id_instr` and `id_pc` are registered; `imem_req`/`id_valid` decode from registered state only, with no combinational input-to-output paths.
- Zero-wait memory: ack in the first `S_FETCH` cycle gives `id_valid=1` on the next cycle.
- Peak throughput is one instruction per 2 cycles (`S_FETCH` → `S_HOLD`).
- `next_pc` is sampled only on an accept edge or a flush edge, so `pc_out` is stable for at least one full cycle before each sample.
- Reset asserted mid-`S_FETCH` or mid-`S_HOLD`: all outputs take their reset values on the next edge, and the pending instruction is lost.

## Configuration
- `IF_STALL_CNT_EN` defined:
  - The `stall_count` port exists.
  - It increments by 1 each cycle with (`S_FETCH` && `!imem_ack`) or (`S_HOLD` && `!id_ready`).
  - It saturates at `32'hFFFF_FFFF` and clears only on reset.
  - `flush` does not clear it.
- `IF_STALL_CNT_EN` undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- `RESET_PC=0`, ack tied high, `id_ready` high, `next_pc=pc_out+1`, reset released → `id_pc` = 0,1,2,3 on alternate cycles; `imem_req` first high in cycle 2 after release.
- ack delayed 3 cycles at `pc=5` → `imem_addr` held at 5 for 4 cycles; then `id_valid=1` with `id_pc=5`; `stall_count` increments by 3.
- `id_ready` low 4 cycles in `S_HOLD` with `id_instr=0x2000_0001` → `id_instr`, `id_pc` and `pc_out` unchanged; `stall_count` +4; the single accept after that advances the PC once.
- `flush` in `S_HOLD` with `next_pc=0x40` → next cycle `id_valid=0`, `imem_req=1`, `imem_addr=0x40`.
- `flush` and `imem_ack` in the same cycle, `rdata=0xDEAD_BEEF`, `next_pc=0x80` → `id_instr` not updated, `id_valid` stays 0, refetch at `0x80`.
- `reset` asserted in `S_HOLD` at `pc=0x10` → next cycle all outputs equal their reset values, then the normal fetch restarts from `RESET_PC`.
